image_sobel_edge: RTL and testbench

Sobel edge detector that consumes the 3X3 window stream produced by the line-buffer matrix stage and returns a single pixel stream. It computes |Gx|+|Gy| per window, saturates to 8 bits, and thresholds to a 1-bit edge map. The border pixels of the frame are forced to zero, using frame-synchronous row/column counters. It sits directly downstream of the matrix generator and feeds binary post-processing (erosion/dilation) or the display path.

---
 rtl/image_pkg.sv | 21 ++
 rtl/image_pixel_counter.sv | 43 ++++
 rtl/image_sobel_edge.sv | 120 ++++++++++++
 tb/tb_image_sobel_edge.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared constants and types for the pixel-stream image blocks
// (matrix generator, line buffer, Sobel, morphology).
package image_pkg;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = 11;
    localparam int SUM_W  = 10;

    localparam logic [9:0] IMG_HDISP      = 10'd640;
    localparam logic [9:0] IMG_VDISP      = 10'd480;
    localparam logic [7:0] THRESH_DEFAULT = 8'd64;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [SUM_W-1:0]  sum_t;
    typedef logic [GRAD_W-1:0] grad_t;

    function automatic sum_t abs_diff(input sum_t a, input sum_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/image_pixel_counter.sv
// Frame-synchronous column/row counter giving the centre coordinate of the
// window being accepted, plus a combinational border flag for that window.
module image_pixel_counter #(
    parameter logic [9:0] H_DISP = image_pkg::IMG_HDISP,
    parameter logic [9:0] V_DISP = image_pkg::IMG_VDISP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       clken,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       border
);

    logic [9:0] col_reg;
    logic [9:0] row_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (vsync) begin
            // a pixel arriving with vsync is tagged (0,0), so the next one is col 1
            col_reg <= clken ? 10'd1 : 10'd0;
            row_reg <= '0;
        end else if (clken) begin
            if (col_reg == H_DISP - 10'd1) begin
                col_reg <= '0;
                row_reg <= (row_reg == V_DISP - 10'd1) ? 10'd0 : row_reg + 10'd1;
            end else begin
                col_reg <= col_reg + 10'd1;
            end
        end
    end

    assign col    = col_reg;
    assign row    = row_reg;
    assign border = vsync
                  | (row_reg == 10'd0) | (row_reg == V_DISP - 10'd1)
                  | (col_reg == 10'd0) | (col_reg == H_DISP - 10'd1);

endmodule

// File: rtl/image_sobel_edge.sv
// Sobel |Gx|+|Gy| edge detector on a 3x3 window stream: three-stage pipeline,
// saturated 8-bit gradient, frame-latched threshold, zeroed frame border.
module image_sobel_edge #(
    parameter logic [9:0] IMG_HDISP      = image_pkg::IMG_HDISP,
    parameter logic [9:0] IMG_VDISP      = image_pkg::IMG_VDISP,
    parameter logic [7:0] THRESH_DEFAULT = image_pkg::THRESH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       matrix_image_clken,
    input  logic [7:0] matrix_p11,
    input  logic [7:0] matrix_p12,
    input  logic [7:0] matrix_p13,
    input  logic [7:0] matrix_p21,
    input  logic [7:0] matrix_p22,
    input  logic [7:0] matrix_p23,
    input  logic [7:0] matrix_p31,
    input  logic [7:0] matrix_p32,
    input  logic [7:0] matrix_p33,
    input  logic [7:0] sobel_threshold,
    output logic       post_image_clken,
    output logic [7:0] post_image_Grad,
    output logic       post_image_Bit
);

    import image_pkg::*;

    logic [9:0] col;
    logic [9:0] row;
    logic       border;

    image_pixel_counter #(
        .H_DISP (IMG_HDISP),
        .V_DISP (IMG_VDISP)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .vsync  (per_frame_vsync),
        .clken  (matrix_image_clken),
        .col    (col),
        .row    (row),
        .border (border)
    );

    logic [2:0] valid_reg;
    pix_t       thresh_reg;
    sum_t       gx_p_reg, gx_n_reg, gy_p_reg, gy_n_reg;
    logic       border1_reg;
    sum_t       gx_abs_reg, gy_abs_reg;
    logic       border2_reg;
    grad_t      sum_next;
    pix_t       grad_reg;
    logic       bit_reg;

    // the p22 centre tap does not enter the Sobel kernels
    logic unused_p22;
    assign unused_p22 = ^matrix_p22;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= '0;
            thresh_reg <= THRESH_DEFAULT;
        end else begin
            valid_reg <= {valid_reg[1:0], matrix_image_clken};
            if (per_frame_vsync)
                thresh_reg <= sobel_threshold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_p_reg    <= '0;
            gx_n_reg    <= '0;
            gy_p_reg    <= '0;
            gy_n_reg    <= '0;
            border1_reg <= 1'b0;
        end else if (matrix_image_clken) begin
            gx_p_reg    <= {2'b0, matrix_p13} + {1'b0, matrix_p23, 1'b0} + {2'b0, matrix_p33};
            gx_n_reg    <= {2'b0, matrix_p11} + {1'b0, matrix_p21, 1'b0} + {2'b0, matrix_p31};
            gy_p_reg    <= {2'b0, matrix_p31} + {1'b0, matrix_p32, 1'b0} + {2'b0, matrix_p33};
            gy_n_reg    <= {2'b0, matrix_p11} + {1'b0, matrix_p12, 1'b0} + {2'b0, matrix_p13};
            border1_reg <= border;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_abs_reg  <= '0;
            gy_abs_reg  <= '0;
            border2_reg <= 1'b0;
        end else if (valid_reg[0]) begin
            gx_abs_reg  <= abs_diff(gx_p_reg, gx_n_reg);
            gy_abs_reg  <= abs_diff(gy_p_reg, gy_n_reg);
            border2_reg <= border1_reg;
        end
    end

    assign sum_next = {1'b0, gx_abs_reg} + {1'b0, gy_abs_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grad_reg <= '0;
            bit_reg  <= 1'b0;
        end else if (valid_reg[1]) begin
            if (border2_reg) begin
                grad_reg <= '0;
                bit_reg  <= 1'b0;
            end else begin
                grad_reg <= (sum_next > 11'd255) ? 8'd255 : sum_next[7:0];
                bit_reg  <= (sum_next > {3'b0, thresh_reg});
            end
        end
    end

    assign post_image_clken = valid_reg[2];
    assign post_image_Grad  = grad_reg;
    assign post_image_Bit   = bit_reg;

endmodule

// File: tb/tb_image_sobel_edge.sv
// Randomized self-checking bench for image_sobel_edge on a reduced 16x8 frame,
// with a queue-based arithmetic reference model and literal pins.
module tb_image_sobel_edge;

    localparam int H = 16;
    localparam int V = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0;
    logic       clken = 1'b0;
    logic [7:0] p11 = 0, p12 = 0, p13 = 0, p21 = 0, p22 = 0, p23 = 0, p31 = 0, p32 = 0, p33 = 0;
    logic [7:0] thr_in = 8'd64;
    logic       post_clken;
    logic [7:0] post_grad;
    logic       post_bit;

    image_sobel_edge #(
        .IMG_HDISP      (10'(H)),
        .IMG_VDISP      (10'(V)),
        .THRESH_DEFAULT (8'd64)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .per_frame_vsync    (vsync),
        .matrix_image_clken (clken),
        .matrix_p11 (p11), .matrix_p12 (p12), .matrix_p13 (p13),
        .matrix_p21 (p21), .matrix_p22 (p22), .matrix_p23 (p23),
        .matrix_p31 (p31), .matrix_p32 (p32), .matrix_p33 (p33),
        .sobel_threshold    (thr_in),
        .post_image_clken   (post_clken),
        .post_image_Grad    (post_grad),
        .post_image_Bit     (post_bit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    grad;
        int    bit_v;
        bit    lit;
        int    lgrad;
        int    lbit;
        string name;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;
    int   m_col = 0, m_row = 0, m_thr = 64;
    bit   hist0 = 0, hist1 = 0, hist2 = 0;
    int   out_count = 0;

    int w_flat[9], w_vert[9], w_weak[9], w_rnd[9];

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sobel_sum(input int w[9]);
        int gx, gy;
        // w: row-major p11,p12,p13,p21,p22,p23,p31,p32,p33
        gx = (w[2] + 2*w[5] + w[8]) - (w[0] + 2*w[3] + w[6]);
        gy = (w[6] + 2*w[7] + w[8]) - (w[0] + 2*w[1] + w[2]);
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    task automatic step(input bit vs, input bit ce, input int w[9], input int th,
                        input bit lit, input int lg, input int lb, input string nm);
        exp_t e;
        int   s;
        bit   brd;
        @(posedge clk);
        #1;
        vsync = vs; clken = ce; thr_in = 8'(th);
        p11 = 8'(w[0]); p12 = 8'(w[1]); p13 = 8'(w[2]);
        p21 = 8'(w[3]); p22 = 8'(w[4]); p23 = 8'(w[5]);
        p31 = 8'(w[6]); p32 = 8'(w[7]); p33 = 8'(w[8]);
        if (vs) m_thr = th;
        if (ce) begin
            brd = vs || m_row == 0 || m_row == V-1 || m_col == 0 || m_col == H-1;
            s = sobel_sum(w);
            e.grad  = brd ? 0 : (s > 255 ? 255 : s);
            e.bit_v = (!brd && s > m_thr) ? 1 : 0;
            e.lit = lit; e.lgrad = lg; e.lbit = lb; e.name = nm;
            expq.push_back(e);
        end
        if (vs) begin
            m_col = ce ? 1 : 0;
            m_row = 0;
        end else if (ce) begin
            if (m_col == H-1) begin
                m_col = 0;
                m_row = (m_row == V-1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic pix(input int w[9], input int th);
        step(0, 1, w, th, 0, 0, 0, "");
    endtask

    task automatic pix_lit(input int w[9], input int th, input int lg, input int lb, input string nm);
        step(0, 1, w, th, 1, lg, lb, nm);
    endtask

    task automatic idle(input int n, input int th);
        for (int i = 0; i < n; i++) step(0, 0, w_flat, th, 0, 0, 0, "");
    endtask

    // idle gap first so no in-flight pixel sees the new threshold
    task automatic frame_start(input int th);
        idle(4, th);
        step(1, 0, w_flat, th, 0, 0, 0, "");
    endtask

    task automatic rand_window();
        int mode = $urandom_range(0, 2);
        for (int i = 0; i < 9; i++) begin
            case (mode)
                0:       w_rnd[i] = $urandom_range(0, 255);
                1:       w_rnd[i] = ($urandom_range(0, 1) == 1) ? 255 : 0;
                default: w_rnd[i] = $urandom_range(0, 40);
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_clken", post_clken, 0);
            check("rst_grad", post_grad, 0);
            check("rst_bit", post_bit, 0);
            hist0 = 0; hist1 = 0; hist2 = 0;
            expq.delete();
        end else begin
            check("clken_delay", post_clken, hist2);
            if (post_clken) begin
                out_count++;
                if (expq.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("grad", post_grad, e.grad);
                    check("bit", post_bit, e.bit_v);
                    if (e.lit) begin
                        check({e.name, "_grad"}, post_grad, e.lgrad);
                        check({e.name, "_bit"}, post_bit, e.lbit);
                    end
                end
            end
            hist2 = hist1; hist1 = hist0; hist0 = clken;
        end
    end

    initial begin
        int th, cnt0;
        w_flat = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
        w_vert = '{0, 128, 255, 0, 128, 255, 0, 128, 255};
        w_weak = '{0, 0, 20, 0, 0, 20, 0, 0, 20};

        check("pin_flat", sobel_sum(w_flat), 0);
        check("pin_vert", sobel_sum(w_vert), 1020);
        check("pin_weak", sobel_sum(w_weak), 80);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // flat field: all zero, one output per input, 3-cycle latency
        frame_start(64);
        cnt0 = out_count;
        for (int i = 0; i < H*V; i++) pix_lit(w_flat, 64, 0, 0, "flat");
        idle(5, 64);
        check("flat_count", out_count - cnt0, H*V);

        // vertical edge: interior saturates, column 0 is border
        frame_start(64);
        for (int i = 0; i < H*V; i++) begin
            if (i == 3*H + 10)      pix_lit(w_vert, 64, 255, 1, "vert_interior");
            else if (i == 3*H)      pix_lit(w_vert, 64, 0, 0, "vert_col0");
            else                    pix(w_flat, 64);
        end

        // weak gradient against threshold 79 then 80; mid-frame change ignored
        frame_start(79);
        for (int i = 0; i < H*V; i++) begin
            if (i == H + 4) pix_lit(w_weak, 79, 80, 1, "weak_t79");
            else            pix(w_weak, 79);
        end
        frame_start(80);
        for (int i = 0; i < H*V; i++) begin
            th = (i >= 10) ? 0 : 80;
            if (i == H + 4)      pix_lit(w_weak, th, 80, 0, "weak_t80");
            else if (i == 2*H+5) pix_lit(w_weak, th, 80, 0, "thr_hold");
            else                 pix(w_weak, th);
        end

        // blanking pattern 1,1,0,1 and vsync coincident with a pixel
        idle(4, 64);
        step(1, 1, w_vert, 64, 1, 0, 0, "vsync_pix");
        pix_lit(w_vert, 64, 0, 0, "vsync_next");
        idle(1, 64);
        pix(w_vert, 64);
        for (int i = 3; i < H + 1; i++) pix(w_vert, 64);
        pix_lit(w_vert, 64, 255, 1, "col1_row1");
        for (int i = H + 2; i < H*V; i++) pix(w_vert, 64);

        // random frames with random blanking and threshold
        for (int f = 0; f < 3; f++) begin
            th = $urandom_range(0, 255);
            frame_start(th);
            for (int i = 0; i < H*V; i++) begin
                if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3), $urandom_range(0, 255));
                rand_window();
                pix(w_rnd, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : th);
            end
        end

        // reset with the pipeline full, then restart without vsync and wrap
        frame_start(30);
        for (int i = 0; i < 50; i++) begin
            rand_window();
            pix(w_rnd, 30);
        end
        @(posedge clk);
        #1;
        clken = 1'b0; vsync = 1'b0; rst_n = 1'b0;
        m_col = 0; m_row = 0; m_thr = 64;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pix_lit(w_vert, 64, 0, 0, "after_reset");
        for (int i = 1; i < H*V; i++) pix(w_vert, 64);
        pix_lit(w_vert, 64, 0, 0, "wrap");
        idle(6, 64);
        check("queue_drained", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
